// File: rtl/banyan_trig_ctrl.sv
// Trigger/arm controller for banyan capture: synchronises the external trigger,
// applies the programmed trigger delay and sequences the capture memory.
module banyan_trig_ctrl #(
  parameter int unsigned dw = 16,
  parameter int unsigned cw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm_i,
  input  logic          force_i,
  input  logic          abort_i,
  input  logic          ext_trig_i,
  input  logic [dw-1:0] trig_delay_i,
  input  logic          data_valid_i,
  input  logic          rollover_i,
  output logic          mem_reset_o,
  output logic          mem_run_o,
  output logic [1:0]    state_o,
  output logic          done_o,
  output logic [cw-1:0] trig_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  logic          sync1_q, sync2_q, hist_q;
  logic          trig_ev;
  logic [1:0]    state_q, state_d;
  logic [dw-1:0] cnt_q, cnt_d;
  logic [cw-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          mem_reset_q, mem_reset_d;
  logic          run_q, run_d;
  logic          start;

  // Two-flop synchroniser plus history flop; runs in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= ext_trig_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign trig_ev = sync2_q & ~hist_q;

  // Control state and capture bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      mem_reset_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      done_q      <= done_d;
      mem_reset_q <= mem_reset_d;
      run_q       <= run_d;
    end
  end

  // Next-state logic; priority abort > force > rollover > trigger > arm
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    done_d      = done_q;
    mem_reset_d = 1'b0;
    run_d       = run_q;
    start       = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      run_d   = 1'b0;
    end else if (force_i) begin
      start = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d = ST_ARMED;
            done_d  = 1'b0;
          end
        end
        ST_ARMED: begin
          if (trig_ev) begin
            if (trig_delay_i == '0) begin
              start = 1'b1;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = trig_delay_i;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q <= dw'(1)) begin
            start = 1'b1;
          end else begin
            cnt_d = cnt_q - dw'(1);
          end
        end
        ST_RUN: begin
          // Rollover is not honoured while the pointer reset is in flight
          if (mem_reset_q) begin
            run_d = 1'b1;
          end else if (rollover_i) begin
            state_d = ST_IDLE;
            run_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = 1'b0;
        end
      endcase
    end

    if (start) begin
      state_d     = ST_RUN;
      mem_reset_d = 1'b1;
      run_d       = 1'b0;
      done_d      = 1'b0;
      count_d     = count_q + cw'(1);
    end
  end

  assign mem_reset_o  = mem_reset_q;
  assign mem_run_o    = run_q & data_valid_i;
  assign state_o      = state_q;
  assign done_o       = done_q;
  assign trig_count_o = count_q;

endmodule

// File: tb/tb_banyan_trig_ctrl.sv
// Self-checking bench for banyan_trig_ctrl against a time-stamped reference model.
module tb_banyan_trig_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, frc, abrt, ext, dv, ro;
  logic [15:0] dly;
  logic        mem_reset, mem_run, done;
  logic [1:0]  state;
  logic [15:0] trig_count;

  always #5 clk = ~clk;

  banyan_trig_ctrl #(.dw(16), .cw(16)) dut (
    .clk(clk), .rst(rst),
    .arm_i(arm), .force_i(frc), .abort_i(abrt), .ext_trig_i(ext),
    .trig_delay_i(dly), .data_valid_i(dv), .rollover_i(ro),
    .mem_reset_o(mem_reset), .mem_run_o(mem_run), .state_o(state),
    .done_o(done), .trig_count_o(trig_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc_no = 0;

  // Reference model: capture phase, absolute start time for delayed triggers,
  // and a history of the ext_trig level seen at each clock edge.
  int          m_state;
  bit          m_done, m_mreset, m_run;
  logic [15:0] m_count;
  int          m_due;
  bit          smp[$];

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic check_all();
    chk1("state",      32'(state),      32'(m_state));
    chk1("mem_reset",  32'(mem_reset),  32'(m_mreset));
    chk1("mem_run",    32'(mem_run),    32'(m_run & dv));
    chk1("done",       32'(done),       32'(m_done));
    chk1("trig_count", 32'(trig_count), 32'(m_count));
  endtask

  task automatic model_reset();
    m_state = 0; m_done = 0; m_mreset = 0; m_run = 0; m_count = '0; m_due = 0;
    smp.delete();
    smp.push_back(1'b0); smp.push_back(1'b0); smp.push_back(1'b0);
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step();
    bit ev, go, was_mreset;
    ev = smp[1] & ~smp[2];
    smp.push_front(ext);
    void'(smp.pop_back());
    cyc_no++;
    go = 0;
    was_mreset = m_mreset;
    m_mreset = 0;
    if (abrt) begin
      m_state = 0; m_run = 0;
    end else if (frc) begin
      go = 1;
    end else begin
      if (m_state == 0 && arm) begin
        m_state = 1; m_done = 0;
      end else if (m_state == 1 && ev) begin
        if (dly == 16'd0) go = 1;
        else begin m_state = 2; m_due = cyc_no + int'(dly); end
      end else if (m_state == 2 && cyc_no == m_due) begin
        go = 1;
      end else if (m_state == 3) begin
        if (was_mreset) m_run = 1;
        else if (ro) begin m_state = 0; m_run = 0; m_done = 1; end
      end
    end
    if (go) begin
      m_state = 3; m_mreset = 1; m_run = 0; m_done = 0; m_count = m_count + 16'd1;
    end
  endtask

  task automatic cyc(input bit a, input bit f, input bit ab, input bit e,
                     input logic [15:0] d, input bit v, input bit r);
    arm = a; frc = f; abrt = ab; ext = e; dly = d; dv = v; ro = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  int rise_edge, mr_edge, n_delay, guard;

  initial begin
    rst = 1'b1; arm = 0; frc = 0; abrt = 0; ext = 0; dly = 16'd5; dv = 0; ro = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 16'd5, 1, 0);

    // Immediate capture by force with continuous valid
    cyc(0, 1, 0, 0, 16'd5, 1, 0);
    chk1("force_mreset", 32'(mem_reset), 32'd1);
    chk1("force_state",  32'(state),     32'd3);
    chk1("force_count",  32'(trig_count), 32'd1);
    cyc(0, 0, 0, 0, 16'd5, 1, 0);
    chk1("force_run", 32'(mem_run), 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 16'd5, 1, 0);
    cyc(0, 0, 1, 0, 16'd5, 1, 0);

    // Armed trigger with delay 5; trig_delay changes mid-delay must not matter
    cyc(1, 0, 0, 0, 16'd5, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 16'd5, 1, 0);
    rise_edge = cyc_no + 1;
    mr_edge = -1; n_delay = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 1, (i < 3) ? 16'd5 : 16'(2 + i), 1, 0);
      if (state == 2'd2) n_delay++;
      if (mem_reset === 1'b1 && mr_edge < 0) mr_edge = cyc_no;
    end
    chk1("delay_cycles",  32'(n_delay), 32'd5);
    chk1("delay_latency", 32'(mr_edge), 32'(rise_edge + 7));

    // Sparse valid then rollover; rollover in IDLE afterwards is ignored
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 16'd5, (i % 4) == 0, i == 11);
    chk1("roll_state", 32'(state), 32'd0);
    chk1("roll_done",  32'(done),  32'd1);
    repeat (3) cyc(0, 0, 0, 0, 16'd5, 1, 1);

    // Level already high at arm: no capture until a fresh rising edge
    repeat (4) cyc(0, 0, 0, 1, 16'd0, 1, 0);
    cyc(1, 0, 0, 1, 16'd0, 1, 0);
    repeat (6) cyc(0, 0, 0, 1, 16'd0, 1, 0);
    chk1("held_armed", 32'(state), 32'd1);
    repeat (2) cyc(0, 0, 0, 0, 16'd0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 16'd0, 1, 0);
    chk1("zero_delay_run", 32'(state), 32'd3);

    // abort and force together during DELAY
    cyc(0, 0, 1, 0, 16'd6, 1, 0);
    cyc(1, 0, 0, 0, 16'd6, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 16'd6, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 16'd6, 1, 0);
    chk1("pre_abort_delay", 32'(state), 32'd2);
    cyc(0, 1, 1, 1, 16'd6, 1, 0);
    chk1("abort_force_state",  32'(state),     32'd0);
    chk1("abort_force_mreset", 32'(mem_reset), 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 16'd6, 1, 0);

    // Counter wrap via back-to-back forces
    guard = 0;
    while (m_count != 16'hFFFF && guard < 70000) begin
      cyc(0, 1, 0, 0, 16'd3, 1, 0);
      guard++;
    end
    chk1("wrap_preload", 32'(trig_count), 32'hFFFF);
    cyc(0, 1, 0, 0, 16'd3, 1, 0);
    chk1("wrap_zero", 32'(trig_count), 32'd0);
    repeat (4) cyc(0, 0, 0, 0, 16'd3, 1, 0);

    // Asynchronous reset mid-capture
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk1("rst_mem_run", 32'(mem_run), 32'd0);
    #1 rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 16'd2, 1, 0);
    repeat (5) cyc(0, 0, 0, 1, 16'd2, 1, 0);
    chk1("rst_needs_arm", 32'(state), 32'd0);

    // Randomised traffic
    begin
      bit e;
      e = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(5) == 0) e = ~e;
        cyc($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(49) == 0,
            e, 16'($urandom_range(7)), 1'($urandom), $urandom_range(11) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
